// File: rtl/branch_predict_tournament_pkg.sv
// Shared helpers for the tournament predictor: saturating counter arithmetic
// and reset encodings that scale with the counter width.
package bp_pkg;

  function automatic int unsigned ctr_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned ctr_weak_taken(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  // Counter values travel as 32-bit quantities; callers narrow to their own width.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
    return (v >= ctr_max(w)) ? ctr_max(w) : v + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned v, input int unsigned w);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_tournament_if.sv
// Fetch-side prediction bus and memory-side training/recovery bus.
interface branch_predict_tournament_if #(
  parameter int unsigned LHT_INDEX_BITS  = 3,
  parameter int unsigned LPHT_INDEX_BITS = 7,
  parameter int unsigned GHR_BITS        = 8
);
  logic [31:0]                pcF;
  logic                       branchF;
  logic                       stallF;
  logic                       predict_takeF;
  logic                       local_takeF;
  logic                       global_takeF;
  logic [LHT_INDEX_BITS-1:0]  lht_indexF;
  logic [LPHT_INDEX_BITS-1:0] lpht_indexF;
  logic [GHR_BITS-1:0]        gpht_indexF;
  logic [GHR_BITS-1:0]        ghr_snapF;

  logic                       branchM;
  logic                       actually_takenM;
  logic                       mispredictM;
  logic                       local_takeM;
  logic                       global_takeM;
  logic [LHT_INDEX_BITS-1:0]  lht_indexM;
  logic [LPHT_INDEX_BITS-1:0] lpht_indexM;
  logic [GHR_BITS-1:0]        gpht_indexM;
  logic [GHR_BITS-1:0]        ghr_snapM;
  logic [31:0]                pcM;

  modport master (
    output pcF, branchF, stallF,
    output branchM, actually_takenM, mispredictM, local_takeM, global_takeM,
    output lht_indexM, lpht_indexM, gpht_indexM, ghr_snapM, pcM,
    input  predict_takeF, local_takeF, global_takeF,
    input  lht_indexF, lpht_indexF, gpht_indexF, ghr_snapF
  );

  modport slave (
    input  pcF, branchF, stallF,
    input  branchM, actually_takenM, mispredictM, local_takeM, global_takeM,
    input  lht_indexM, lpht_indexM, gpht_indexM, ghr_snapM, pcM,
    output predict_takeF, local_takeF, global_takeF,
    output lht_indexF, lpht_indexF, gpht_indexF, ghr_snapF
  );
endinterface

// File: rtl/branch_predict_tournament_sat_counter_table.sv
// Table of saturating counters: one combinational read port, one
// up/down write port, whole-table synchronous reset.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_up
);
  localparam int unsigned DEPTH = 2 ** INDEX_BITS;

  logic [CTR_BITS-1:0] mem [DEPTH];

  // Reads see the pre-edge contents; a same-cycle write is not bypassed.
  assign rd_ctr = mem[rd_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= CTR_BITS'(RESET_VAL);
      end
    end else if (wr_en) begin
      if (wr_up) begin
        mem[wr_index] <= CTR_BITS'(sat_inc(32'(mem[wr_index]), CTR_BITS));
      end else begin
        mem[wr_index] <= CTR_BITS'(sat_dec(32'(mem[wr_index]), CTR_BITS));
      end
    end
  end

endmodule

// File: rtl/branch_predict_tournament.sv
// Tournament direction predictor: local-history and gshare components with a
// per-PC chooser; speculative GHR with checkpoint recovery on mispredict.
module branch_predict_tournament
  import bp_pkg::*;
#(
  parameter int unsigned PC_TAIL            = 2,
  parameter int unsigned LHT_INDEX_BITS     = 3,
  parameter int unsigned LHR_BITS           = 4,
  parameter int unsigned LPHT_INDEX_BITS    = 7,
  parameter int unsigned GHR_BITS           = 8,
  parameter int unsigned CHOOSER_INDEX_BITS = 8,
  parameter int unsigned CTR_BITS           = 2
) (
  input logic clk,
  input logic rst,
  branch_predict_tournament_if.slave bus
);
  localparam int unsigned LHT_DEPTH = 2 ** LHT_INDEX_BITS;
  localparam int unsigned LPC_BITS  = LPHT_INDEX_BITS - LHR_BITS;

  logic [LHR_BITS-1:0]           lht [LHT_DEPTH];
  logic [GHR_BITS-1:0]           ghr;

  logic [LHT_INDEX_BITS-1:0]     lht_idx;
  logic [LPHT_INDEX_BITS-1:0]    lpht_idx;
  logic [GHR_BITS-1:0]           gpht_idx;
  logic [CHOOSER_INDEX_BITS-1:0] cho_rd_idx;
  logic [CHOOSER_INDEX_BITS-1:0] cho_wr_idx;
  logic [CTR_BITS-1:0]           lpht_ctr;
  logic [CTR_BITS-1:0]           gpht_ctr;
  logic [CTR_BITS-1:0]           cho_ctr;
  logic                          local_take;
  logic                          global_take;
  logic                          predict_take;
  logic                          cho_wr_en;
  logic                          cho_wr_up;

  always_comb begin
    lht_idx      = bus.pcF[PC_TAIL +: LHT_INDEX_BITS];
    lpht_idx     = {bus.pcF[PC_TAIL +: LPC_BITS], lht[lht_idx]};
    gpht_idx     = bus.pcF[PC_TAIL +: GHR_BITS] ^ ghr;
    cho_rd_idx   = bus.pcF[PC_TAIL +: CHOOSER_INDEX_BITS];
    cho_wr_idx   = bus.pcM[PC_TAIL +: CHOOSER_INDEX_BITS];
    local_take   = lpht_ctr[CTR_BITS-1];
    global_take  = gpht_ctr[CTR_BITS-1];
    predict_take = cho_ctr[CTR_BITS-1] ? global_take : local_take;
    // Chooser only learns when the components disagree, toward whichever was right.
    cho_wr_en    = bus.branchM && (bus.local_takeM != bus.global_takeM);
    cho_wr_up    = (bus.global_takeM == bus.actually_takenM);
  end

  assign bus.predict_takeF = predict_take;
  assign bus.local_takeF   = local_take;
  assign bus.global_takeF  = global_take;
  assign bus.lht_indexF    = lht_idx;
  assign bus.lpht_indexF   = lpht_idx;
  assign bus.gpht_indexF   = gpht_idx;
  assign bus.ghr_snapF     = ghr;

  sat_counter_table #(
    .INDEX_BITS (LPHT_INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .RESET_VAL  (ctr_weak_taken(CTR_BITS))
  ) u_lpht (
    .clk      (clk),
    .rst      (rst),
    .rd_index (lpht_idx),
    .rd_ctr   (lpht_ctr),
    .wr_en    (bus.branchM),
    .wr_index (bus.lpht_indexM),
    .wr_up    (bus.actually_takenM)
  );

  sat_counter_table #(
    .INDEX_BITS (GHR_BITS),
    .CTR_BITS   (CTR_BITS),
    .RESET_VAL  (ctr_weak_taken(CTR_BITS))
  ) u_gpht (
    .clk      (clk),
    .rst      (rst),
    .rd_index (gpht_idx),
    .rd_ctr   (gpht_ctr),
    .wr_en    (bus.branchM),
    .wr_index (bus.gpht_indexM),
    .wr_up    (bus.actually_takenM)
  );

  sat_counter_table #(
    .INDEX_BITS (CHOOSER_INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .RESET_VAL  (ctr_weak_not_taken(CTR_BITS))
  ) u_chooser (
    .clk      (clk),
    .rst      (rst),
    .rd_index (cho_rd_idx),
    .rd_ctr   (cho_ctr),
    .wr_en    (cho_wr_en),
    .wr_index (cho_wr_idx),
    .wr_up    (cho_wr_up)
  );

  // Mispredict recovery rebuilds history from the checkpoint and overrides
  // any speculative shift from a branch being fetched in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LHT_DEPTH; i++) begin
        lht[i] <= '0;
      end
      ghr <= '0;
    end else begin
      if (bus.branchM) begin
        lht[bus.lht_indexM] <= {lht[bus.lht_indexM][LHR_BITS-2:0], bus.actually_takenM};
      end
      if (bus.branchM && bus.mispredictM) begin
        ghr <= {bus.ghr_snapM[GHR_BITS-2:0], bus.actually_takenM};
      end else if (bus.branchF && !bus.stallF) begin
        ghr <= {ghr[GHR_BITS-2:0], predict_take};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Self-checking bench for branch_predict_tournament: directed scenarios plus
// randomized traffic compared against an arithmetic model of the tables.
module tb_branch_predict_tournament;
  localparam int unsigned LHT_N  = 8;
  localparam int unsigned LPHT_N = 128;
  localparam int unsigned GPHT_N = 256;
  localparam int unsigned CHO_N  = 256;
  localparam int          CMAX   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_tournament_if #(
    .LHT_INDEX_BITS (3),
    .LPHT_INDEX_BITS(7),
    .GHR_BITS       (8)
  ) bus ();

  branch_predict_tournament #(
    .PC_TAIL           (2),
    .LHT_INDEX_BITS    (3),
    .LHR_BITS          (4),
    .LPHT_INDEX_BITS   (7),
    .GHR_BITS          (8),
    .CHOOSER_INDEX_BITS(8),
    .CTR_BITS          (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int lpht_m [LPHT_N];
  int gpht_m [GPHT_N];
  int cho_m  [CHO_N];
  int lht_m  [LHT_N];
  int ghr_m;
  int m_lht_i, m_lpht_i, m_gpht_i, m_snap;
  bit m_local, m_global, m_pred;

  task automatic model_reset();
    for (int i = 0; i < LPHT_N; i++) lpht_m[i] = 2;
    for (int i = 0; i < GPHT_N; i++) gpht_m[i] = 2;
    for (int i = 0; i < CHO_N; i++)  cho_m[i]  = 1;
    for (int i = 0; i < LHT_N; i++)  lht_m[i]  = 0;
    ghr_m = 0;
  endtask

  task automatic model_predict();
    int w;
    w        = int'(bus.pcF >> 2);
    m_lht_i  = w % 8;
    m_lpht_i = (w % 8) * 16 + lht_m[m_lht_i];
    m_gpht_i = (w % 256) ^ ghr_m;
    m_snap   = ghr_m;
    m_local  = (lpht_m[m_lpht_i] >= 2);
    m_global = (gpht_m[m_gpht_i] >= 2);
    m_pred   = (cho_m[w % 256] >= 2) ? m_global : m_local;
  endtask

  task automatic model_update();
    int li, gi, hi, ci;
    bit t;
    if (rst) begin
      model_reset();
    end else begin
      t = bus.actually_takenM;
      if (bus.branchM) begin
        li = int'(bus.lpht_indexM);
        gi = int'(bus.gpht_indexM);
        hi = int'(bus.lht_indexM);
        lpht_m[li] = t ? ((lpht_m[li] < CMAX) ? lpht_m[li] + 1 : CMAX)
                       : ((lpht_m[li] > 0) ? lpht_m[li] - 1 : 0);
        gpht_m[gi] = t ? ((gpht_m[gi] < CMAX) ? gpht_m[gi] + 1 : CMAX)
                       : ((gpht_m[gi] > 0) ? gpht_m[gi] - 1 : 0);
        if (bus.local_takeM != bus.global_takeM) begin
          ci = int'(bus.pcM >> 2) % 256;
          if (bus.global_takeM == t)
            cho_m[ci] = (cho_m[ci] < CMAX) ? cho_m[ci] + 1 : CMAX;
          else
            cho_m[ci] = (cho_m[ci] > 0) ? cho_m[ci] - 1 : 0;
        end
        lht_m[hi] = (lht_m[hi] * 2 + int'(t)) % 16;
      end
      if (bus.branchM && bus.mispredictM)
        ghr_m = (int'(bus.ghr_snapM) * 2 + int'(t)) % 256;
      else if (bus.branchF && !bus.stallF)
        ghr_m = (ghr_m * 2 + int'(m_pred)) % 256;
    end
  endtask

  // One clock: compare every output against the model at the falling edge,
  // then advance the model with the inputs the DUT sees at the rising edge.
  task automatic step();
    @(negedge clk);
    model_predict();
    check("predict", 32'(bus.predict_takeF), 32'(m_pred));
    check("local",   32'(bus.local_takeF),   32'(m_local));
    check("global",  32'(bus.global_takeF),  32'(m_global));
    check("lht_idx", 32'(bus.lht_indexF),    32'(m_lht_i));
    check("lpht_idx",32'(bus.lpht_indexF),   32'(m_lpht_i));
    check("gpht_idx",32'(bus.gpht_indexF),   32'(m_gpht_i));
    check("ghr_snap",32'(bus.ghr_snapF),     32'(m_snap));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pcF = '0; bus.branchF = 1'b0; bus.stallF = 1'b0;
    bus.branchM = 1'b0; bus.actually_takenM = 1'b0; bus.mispredictM = 1'b0;
    bus.local_takeM = 1'b0; bus.global_takeM = 1'b0;
    bus.lht_indexM = '0; bus.lpht_indexM = '0; bus.gpht_indexM = '0;
    bus.ghr_snapM = '0; bus.pcM = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] loop_pc;
    bit          outcome;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;

    // Reset state and index formation
    do_reset();
    bus.pcF = 32'h0040_0010;
    #1;
    check("rst_pred",  32'(bus.predict_takeF), 32'd1);
    check("rst_lht",   32'(bus.lht_indexF),    32'd4);
    check("rst_lpht",  32'(bus.lpht_indexF),   32'h40);
    check("rst_gpht",  32'(bus.gpht_indexF),   32'h04);
    check("rst_snap",  32'(bus.ghr_snapF),     32'h00);
    step();

    // LPHT saturation at 0, then recovery at +2 (a wrap would still read not-taken)
    bus.branchM = 1'b1; bus.actually_takenM = 1'b0;
    bus.lpht_indexM = 7'h40; bus.lht_indexM = 3'd5; bus.gpht_indexM = 8'h10;
    bus.local_takeM = 1'b1; bus.global_takeM = 1'b1;
    repeat (3) step();
    bus.branchM = 1'b0;
    #1;
    check("lpht_sat0", 32'(bus.local_takeF), 32'd0);
    bus.branchM = 1'b1; bus.actually_takenM = 1'b1;
    repeat (2) step();
    bus.branchM = 1'b0;
    #1;
    check("lpht_up2", 32'(bus.local_takeF), 32'd1);
    step();

    // Speculative GHR shifts, stall holds, recovery wins over F
    do_reset();
    idle_inputs();
    bus.pcF = 32'h0040_0010; bus.branchF = 1'b1;
    repeat (3) step();
    bus.stallF = 1'b1;
    #1;
    check("ghr_spec3", 32'(bus.ghr_snapF), 32'h07);
    step();
    check("ghr_stall", 32'(bus.ghr_snapF), 32'h07);
    bus.stallF = 1'b0;
    bus.branchM = 1'b1; bus.mispredictM = 1'b1; bus.ghr_snapM = 8'h05;
    bus.actually_takenM = 1'b0;
    step();
    idle_inputs();
    bus.pcF = 32'h0040_0010;
    #1;
    check("ghr_recover", 32'(bus.ghr_snapF), 32'h0A);
    step();

    // Chooser moves to global on disagreement, holds on agreement
    do_reset();
    idle_inputs();
    bus.pcF = 32'h0040_0010;
    bus.branchM = 1'b1; bus.local_takeM = 1'b1; bus.global_takeM = 1'b1;
    bus.actually_takenM = 1'b0; bus.gpht_indexM = 8'h04; bus.lpht_indexM = 7'h00;
    bus.lht_indexM = 3'd7; bus.pcM = 32'h0040_0000;
    repeat (2) step();
    bus.branchM = 1'b0;
    #1;
    check("cho_g_nt",   32'(bus.global_takeF),  32'd0);
    check("cho_local",  32'(bus.predict_takeF), 32'd1);
    bus.branchM = 1'b1; bus.global_takeM = 1'b0;
    bus.gpht_indexM = 8'hFF; bus.lpht_indexM = 7'h01; bus.pcM = 32'h0040_0010;
    step();
    bus.branchM = 1'b0;
    #1;
    check("cho_global", 32'(bus.predict_takeF), 32'd0);
    bus.branchM = 1'b1; bus.global_takeM = 1'b1; bus.actually_takenM = 1'b1;
    step();
    bus.branchM = 1'b0;
    #1;
    check("cho_agree",  32'(bus.predict_takeF), 32'd0);
    step();

    // T,T,T,N loop with in-order feedback; reset mid-loop
    do_reset();
    idle_inputs();
    loop_pc = 32'h0040_0020;
    for (int it = 0; it < 12; it++) begin
      for (int b = 0; b < 4; b++) begin
        outcome = (b != 3);
        bus.pcF = loop_pc; bus.branchF = 1'b1; bus.branchM = 1'b0;
        #1;
        if (it >= 4 && it < 10) check("loop_pred", 32'(bus.predict_takeF), 32'(outcome));
        step();
        bus.branchF = 1'b0; bus.branchM = 1'b1; bus.actually_takenM = outcome;
        bus.mispredictM = (m_pred != outcome);
        bus.local_takeM = m_local; bus.global_takeM = m_global;
        bus.lht_indexM = 3'(m_lht_i); bus.lpht_indexM = 7'(m_lpht_i);
        bus.gpht_indexM = 8'(m_gpht_i); bus.ghr_snapM = 8'(m_snap); bus.pcM = loop_pc;
        if (it == 11 && b == 1) rst = 1'b1;
        step();
        if (it == 11 && b == 1) begin
          rst = 1'b0;
          bus.branchM = 1'b0;
          #1;
          check("mid_rst_pred",  32'(bus.predict_takeF), 32'd1);
          check("mid_rst_local", 32'(bus.local_takeF),   32'd1);
          check("mid_rst_glob",  32'(bus.global_takeF),  32'd1);
          check("mid_rst_snap",  32'(bus.ghr_snapF),     32'd0);
        end
      end
    end

    // Randomized traffic; half the M slots replay the previous F lookup
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      bit replay;
      replay = ($urandom_range(1) == 1);
      rst = ($urandom_range(99) == 0);
      bus.branchM = ($urandom_range(1) == 1);
      bus.actually_takenM = ($urandom_range(1) == 1);
      bus.mispredictM = ($urandom_range(1) == 1);
      if (replay) begin
        bus.local_takeM = m_local; bus.global_takeM = m_global;
        bus.lht_indexM = 3'(m_lht_i); bus.lpht_indexM = 7'(m_lpht_i);
        bus.gpht_indexM = 8'(m_gpht_i); bus.ghr_snapM = 8'(m_snap); bus.pcM = bus.pcF;
      end else begin
        bus.local_takeM = ($urandom_range(1) == 1);
        bus.global_takeM = ($urandom_range(1) == 1);
        bus.lht_indexM = 3'($urandom_range(7));
        bus.lpht_indexM = 7'($urandom_range(127));
        bus.gpht_indexM = 8'($urandom_range(255));
        bus.ghr_snapM = 8'($urandom_range(255));
        bus.pcM = 32'h0040_0000 | (32'($urandom_range(15)) << 2);
      end
      bus.pcF = 32'h0040_0000 | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      bus.branchF = ($urandom_range(1) == 1);
      bus.stallF = ($urandom_range(3) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
